// File: rtl/fetch_prefetch.sv
// Sequential instruction fetch stage with a DEPTH-entry {pc, instr} prefetch queue and redirect flush.
// Optional macro FETCH_BYPASS_EN: an arriving response is shown to decode in its own cycle when the queue is empty.
module fetch_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            resp_valid_i,
    input  logic [XLEN-1:0] resp_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            stall_o
);

    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   discard;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [XLEN-1:0] instr_q [DEPTH];

    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          resp_drop;
    logic          resp_take;
    logic          q_empty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Request issue: queue slots are reserved for every in-flight request, so a response always has room.
    assign credit_used = SW'(count) + SW'(outstanding);
    assign req_valid_o = rst_n_i && !redirect_i
                         && (outstanding < OW'(MAX_OUT))
                         && (credit_used < SW'(DEPTH));
    assign req_addr_o  = fetch_pc;
    assign req_fire    = req_valid_o && req_ready_i;

    // Response stage: a response arriving with a redirect is stale, like those counted in discard.
    assign resp_drop = resp_valid_i && (redirect_i || (discard != '0));
    assign resp_take = resp_valid_i && !resp_drop;
    assign q_empty   = (count == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = rst_n_i && q_empty && resp_take;
`else
    assign bypass = 1'b0;
`endif

    // Decode stage: head comes from queue storage, or straight from the response when bypassing.
    assign instr_valid_o = !q_empty || bypass;
    assign stall_o       = !instr_valid_o;
    assign pop           = !q_empty && instr_ready_i && !redirect_i;
    assign push          = resp_take && !(bypass && instr_ready_i);

    always_comb begin
        instr_o = '0;
        pc_o    = '0;
        if (!q_empty) begin
            instr_o = instr_q[rd_ptr];
            pc_o    = pc_q[rd_ptr];
        end else if (bypass) begin
            instr_o = resp_data_i;
            pc_o    = resp_pc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_q[wr_ptr]    <= resp_pc;
            instr_q[wr_ptr] <= resp_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(resp_valid_i);
            if (redirect_i) begin
                fetch_pc <= redirect_pc_i;
                resp_pc  <= redirect_pc_i;
                // Everything still in flight after this cycle belongs to the old path.
                discard  <= outstanding - OW'(resp_valid_i);
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (resp_take) begin
                    resp_pc <= resp_pc + XLEN'(4);
                end
                if (resp_drop) begin
                    discard <= discard - OW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, backpressure, redirects, async reset, bypass, PC wrap.
module tb_fetch_prefetch;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        req_valid_o;
    logic        req_ready_i = 1'b0;
    logic [31:0] req_addr_o;
    logic        resp_valid_i = 1'b0;
    logic [31:0] resp_data_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        stall_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic        auto_resp = 1'b0;
    logic [31:0] pend[$];

    always #5 clk_i = ~clk_i;

    fetch_prefetch #(
        .XLEN(32), .DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .stall_o(stall_o)
    );

    // One clock; a 1-cycle cache answers accepted requests with data 0x1000_0000 | addr when auto_resp is set.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk_i);
        acc = req_valid_o && req_ready_i;
        a   = req_addr_o;
        @(posedge clk_i);
        #1;
        if (acc) pend.push_back(a);
        if (auto_resp && pend.size() > 0) begin
            resp_valid_i = 1'b1;
            resp_data_i  = 32'h1000_0000 | pend.pop_front();
        end else begin
            resp_valid_i = 1'b0;
            resp_data_i  = '0;
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0; req_ready_i = 1'b0;
        resp_valid_i = 1'b0; resp_data_i = '0; instr_ready_i = 1'b0; auto_resp = 1'b0;
        tick(); tick();
        pend.delete();
        rst_n_i = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; req_ready_i = 1'b1; auto_resp = 1'b0;
        tick(); tick();
        n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", instr_valid_o); end
        n_vec++; if (instr_o !== 32'h0) begin n_err++; $display("FAIL rst_instr got=%h exp=0", instr_o); end
        n_vec++; if (pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=0", pc_o); end
        n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rst_stall got=%b exp=1", stall_o); end
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_req_valid got=%b exp=0", req_valid_o); end
        pend.delete();
        rst_n_i = 1'b1;
        #1;
        n_vec++; if (req_valid_o !== 1'b1) begin n_err++; $display("FAIL rst_first_req got=%b exp=1", req_valid_o); end
        n_vec++; if (req_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_first_addr got=%h exp=0", req_addr_o); end
    endtask

    task automatic test_stream();
`ifdef FETCH_BYPASS_EN
        int lat = 1;
`else
        int lat = 2;
`endif
        logic [31:0] exp_pc;
        do_reset();
        req_ready_i = 1'b1; instr_ready_i = 1'b1; auto_resp = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            n_vec++; if (req_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_req_valid k=%0d got=%b exp=1", k, req_valid_o); end
            n_vec++; if (req_addr_o !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, req_addr_o, 32'(4 * k)); end
            if (k >= lat) begin
                exp_pc = 32'(4 * (k - lat));
                n_vec++; if (instr_valid_o !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, instr_valid_o); end
                n_vec++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, pc_o, exp_pc); end
                n_vec++; if (instr_o !== (32'h1000_0000 | exp_pc)) begin n_err++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, instr_o, 32'h1000_0000 | exp_pc); end
                n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL stream_stall k=%0d got=%b exp=0", k, stall_o); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        req_ready_i = 1'b1; instr_ready_i = 1'b0; auto_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'(4 * k)) begin
                n_err++; $display("FAIL fill_req k=%0d got=%b/%h exp=1/%h", k, req_valid_o, req_addr_o, 32'(4 * k));
            end
            tick();
        end
        #1;
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL credit_stop got=%b exp=0", req_valid_o); end
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin n_err++; $display("FAIL full_head got=%b/%h exp=1/0", instr_valid_o, pc_o); end
        tick(); tick(); tick();
        #1;
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL full_hold got=%b exp=0", req_valid_o); end
        instr_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== exp_pc[i]) begin
                n_err++; $display("FAIL drain_pc i=%0d got=%b/%h exp=1/%h", i, instr_valid_o, pc_o, exp_pc[i]);
            end
            n_vec++; if (instr_o !== (32'h1000_0000 | exp_pc[i])) begin
                n_err++; $display("FAIL drain_instr i=%0d got=%h exp=%h", i, instr_o, 32'h1000_0000 | exp_pc[i]);
            end
            if (i == 0) begin
                n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_req0 got=%b exp=0", req_valid_o); end
            end
            if (i == 1) begin
                n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h10) begin
                    n_err++; $display("FAIL drain_req1 got=%b/%h exp=1/00000010", req_valid_o, req_addr_o);
                end
            end
            tick();
        end
    endtask

    // Stream until 0x10 is accepted and then hold back further auto responses.
    task automatic run_to_c5();
        do_reset();
        req_ready_i = 1'b1; instr_ready_i = 1'b1; auto_resp = 1'b1;
        tick(); tick(); tick(); tick();
        auto_resp = 1'b0;
        tick();
    endtask

    task automatic test_redirect();
        run_to_c5();
        tick();
        #1;
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_maxout got=%b exp=0", req_valid_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h100; instr_ready_i = 1'b0;
        #1;
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_req_forced got=%b exp=0", req_valid_o); end
        tick();
        redirect_i = 1'b0;
        #1;
        n_vec++; if (req_addr_o !== 32'h100) begin n_err++; $display("FAIL rd_target got=%h exp=00000100", req_addr_o); end
        n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_flush got=%b exp=0", instr_valid_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'hBAD0_0010;
        #1;
        n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_stale0 got=%b exp=0", instr_valid_o); end
        tick();
        resp_valid_i = 1'b1; resp_data_i = 32'hBAD0_0014;
        #1;
        n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h100) begin
            n_err++; $display("FAIL rd_req_after got=%b/%h exp=1/00000100", req_valid_o, req_addr_o);
        end
        n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL rd_stale1 got=%b exp=0", instr_valid_o); end
        tick();
        #1;
        n_vec++; if (req_addr_o !== 32'h104) begin n_err++; $display("FAIL rd_next_addr got=%h exp=00000104", req_addr_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'h1000_0100;
        tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h100) begin
            n_err++; $display("FAIL rd_new_head got=%b/%h exp=1/00000100", instr_valid_o, pc_o);
        end
        n_vec++; if (instr_o !== 32'h1000_0100) begin n_err++; $display("FAIL rd_new_instr got=%h exp=10000100", instr_o); end
    endtask

    task automatic test_redirect_same_cycle();
        run_to_c5();
        redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b0;
        resp_valid_i = 1'b1; resp_data_i = 32'hBAD0_0010;
        #1;
        n_vec++; if (req_valid_o !== 1'b0) begin n_err++; $display("FAIL rs_req_forced got=%b exp=0", req_valid_o); end
        tick();
        redirect_i = 1'b0;
        #1;
        n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h200) begin
            n_err++; $display("FAIL rs_first_req got=%b/%h exp=1/00000200", req_valid_o, req_addr_o);
        end
        n_vec++; if (instr_valid_o !== 1'b0 || stall_o !== 1'b1) begin
            n_err++; $display("FAIL rs_flush got=%b/%b exp=0/1", instr_valid_o, stall_o);
        end
        tick();
        #1;
        n_vec++; if (req_addr_o !== 32'h204) begin n_err++; $display("FAIL rs_next_addr got=%h exp=00000204", req_addr_o); end
        resp_valid_i = 1'b1; resp_data_i = 32'h1000_0200;
        tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h200 || instr_o !== 32'h1000_0200) begin
            n_err++; $display("FAIL rs_new_head got=%b/%h/%h exp=1/00000200/10000200", instr_valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_ready_i = 1'b1; instr_ready_i = 1'b0; auto_resp = 1'b1;
        tick(); tick(); tick(); tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
            n_err++; $display("FAIL rm_pre got=%b/%h exp=1/0", instr_valid_o, pc_o);
        end
        rst_n_i = 1'b0;
        #1;
        n_vec++; if (instr_valid_o !== 1'b0 || instr_o !== 32'h0 || pc_o !== 32'h0) begin
            n_err++; $display("FAIL rm_async got=%b/%h/%h exp=0/0/0", instr_valid_o, instr_o, pc_o);
        end
        n_vec++; if (stall_o !== 1'b1 || req_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rm_ctrl got=%b/%b exp=1/0", stall_o, req_valid_o);
        end
        auto_resp = 1'b0; resp_valid_i = 1'b0;
        tick(); tick();
        pend.delete();
        rst_n_i = 1'b1;
        #1;
        n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0) begin
            n_err++; $display("FAIL rm_restart got=%b/%h exp=1/0", req_valid_o, req_addr_o);
        end
        auto_resp = 1'b1;
        tick(); tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1000_0000) begin
            n_err++; $display("FAIL rm_first_head got=%b/%h/%h exp=1/0/10000000", instr_valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        req_ready_i = 1'b1; instr_ready_i = 1'b0;
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        #1;
        n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h40) begin
            n_err++; $display("FAIL bp_req got=%b/%h exp=1/00000040", req_valid_o, req_addr_o);
        end
        tick();
        resp_valid_i = 1'b1; resp_data_i = 32'hDEAD_BEEF;
        #1;
`ifdef FETCH_BYPASS_EN
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== 32'hDEAD_BEEF || stall_o !== 1'b0) begin
            n_err++; $display("FAIL bp_same_cycle got=%b/%h/%h/%b exp=1/00000040/deadbeef/0", instr_valid_o, pc_o, instr_o, stall_o);
        end
`else
        n_vec++; if (instr_valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== 32'h0 || stall_o !== 1'b1) begin
            n_err++; $display("FAIL bp_same_cycle got=%b/%h/%h/%b exp=0/0/0/1", instr_valid_o, pc_o, instr_o, stall_o);
        end
`endif
        tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b1 || pc_o !== 32'h40 || instr_o !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL bp_next_cycle got=%b/%h/%h exp=1/00000040/deadbeef", instr_valid_o, pc_o, instr_o);
        end
        instr_ready_i = 1'b1;
        tick();
        #1;
        n_vec++; if (instr_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_popped got=%b exp=0", instr_valid_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        req_ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        #1;
        n_vec++; if (req_addr_o !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top got=%h exp=fffffffc", req_addr_o); end
        tick();
        #1;
        n_vec++; if (req_valid_o !== 1'b1 || req_addr_o !== 32'h0) begin
            n_err++; $display("FAIL wrap_zero got=%b/%h exp=1/0", req_valid_o, req_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_same_cycle();
        test_reset_mid();
        test_bypass();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised instruction fetch stage with a prefetch queue.
- Issues sequential PC requests to the instruction cache over a valid/ready request channel.
- Accepts in-order responses and buffers {pc, instr} pairs in a DEPTH-entry queue.
- Presents the queue head to decode with a valid/ready handshake.
- Branch redirects flush the queue and discard stale in-flight responses using a discard counter.

Parameters:
XLEN, 32, width of PC and instruction.
DEPTH, 4, prefetch queue entries (power of 2, >=2).
MAX_OUT, 2, maximum outstanding cache requests (>=1).
RESET_PC, 0, first fetch address after reset.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
redirect_i  in  1  branch/redirect strobe
redirect_pc_i  in  XLEN  redirect target (word aligned)
req_valid_o  out  1  cache request valid
req_ready_i  in  1  cache accepts request
req_addr_o  out  XLEN  request address
resp_valid_i  in  1  cache response valid (in order, always accepted)
resp_data_i  in  XLEN  response instruction
instr_valid_o  out  1  queue head valid
instr_ready_i  in  1  decode consumes head
instr_o  out  XLEN  head instruction, 0 when invalid
pc_o  out  XLEN  head PC, 0 when invalid
stall_o  out  1  high when instr_valid_o low (decode starved)

Behaviour:
- Reset is asynchronous and active-low (rst_n_i):
  - fetch_pc = RESET_PC, resp_pc = RESET_PC.
  - Queue empty; outstanding = 0; discard = 0.
  - Outputs: instr_valid_o = 0, instr_o = 0, pc_o = 0, stall_o = 1.
  - req_valid_o = 0 during reset; it may assert in the first cycle after deassertion.
  - Reset mid-operation drops everything; in-flight responses after reset are not discarded (the cache is reset by the same signal).
- Request issue:
  - req_valid_o = !redirect_i && (outstanding < MAX_OUT) && (count + outstanding < DEPTH), where count = queue occupancy. This credit rule guarantees no response is ever refused.
  - req_addr_o = fetch_pc.
  - On req_valid_o && req_ready_i: fetch_pc += 4 and outstanding += 1.
- Response:
  - If discard > 0: drop the response; discard -= 1; outstanding -= 1.
  - Otherwise: push {resp_pc, resp_data_i}; resp_pc += 4; outstanding -= 1.
- Decode handshake:
  - Pop when instr_valid_o && instr_ready_i.
  - Head outputs are registered queue storage; default latency is response cycle N, instr_valid_o at N+1.
  - Simultaneous push and pop is legal at any occupancy, including full (count unchanged).
- Redirect (highest priority):
  - fetch_pc and resp_pc load redirect_pc_i; queue emptied.
  - discard += outstanding, net of any response arriving in that same cycle, which is itself discarded.
  - req_valid_o is forced low in the redirect cycle, so no stale request is accepted.
  - A pop in the redirect cycle is ignored: decode must already ignore the head when redirecting.
  - instr_valid_o = 0 in the following cycle.
  - First request to redirect_pc_i is issued in the cycle after redirect_i.
- Widths: outstanding and discard counters are clog2(MAX_OUT+1) bits; queue pointers are clog2(DEPTH) bits and wrap; count is clog2(DEPTH+1) bits.
- PC increments wrap modulo 2^XLEN.
- Invariant: discard <= outstanding <= MAX_OUT at all times.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty and a non-discarded response arrives, instr_valid_o/instr_o/pc_o reflect it combinationally in the same cycle.
  - If instr_ready_i is also high, the entry is consumed without being written.
  - Otherwise it is written to the queue as normal.
- Undefined: no combinational path from resp_* to the outputs; minimum latency is 1 cycle.

Test Plan:
- Reset, req_ready_i = 1, 1-cycle cache, instr_ready_i = 1 -> req_addr_o sequence 0x0, 0x4, 0x8...; instr_o/pc_o pairs match in order; stall_o low once streaming.
- instr_ready_i = 0, always-ready cache -> exactly 4 responses buffered, req_valid_o drops with count + outstanding = 4; releasing ready drains pc 0x0..0xC in order.
- Two requests outstanding (0x10, 0x14), redirect_i with 0x100 -> both later responses dropped; next instr_valid_o shows pc_o = 0x100; discard returns to 0.
- redirect_i in the same cycle as resp_valid_i for 0x10 -> that response is dropped; no stale request accepted that cycle; first request after redirect is 0x200.
- Reset asserted mid-stream with 3 entries queued -> outputs 0 immediately (asynchronous); after release, first req_addr_o = RESET_PC.
- Empty queue, response 0xDEADBEEF at pc 0x40 -> same-cycle instr_valid_o with FETCH_BYPASS_EN; one cycle later without it.
